sysu_serial_cmp_ctrl: RTL and testbench
=======================================

# sysu_serial_cmp_ctrl

Sequential controller for wide-word magnitude comparison using a single 4-bit cascadable comparator slice.
- On a START request it captures two NIBBLES×4-bit operands and the three cascade inputs, then walks the slice from the most-significant nibble downward, one nibble per clock.
- It terminates early on the first unequal nibble.
- It sits between a requesting datapath (ALU flag logic, sort unit) and the comparator resource, replacing a long combinational cascade chain with a bounded-latency serial one.

## Interface
Parameters:
- NIBBLES, 4, operand width in nibbles (operand width W = 4×NIBBLES); legal range 1..16.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  reset, asynchronous and active-high.
- START  in  1  request; sampled only while idle.
- A  in  W  operand A, unsigned; captured on the accepted START edge.
- B  in  W  operand B, unsigned; captured on the accepted START edge.
- IAgB, IAeB, IAlB  in  1 each  cascade inputs; captured with the operands.
- BUSY  out  1  high while a comparison is in progress.
- DONE  out  1  one-cycle pulse; result valid.
- QAgB, QAeB, QAlB  out  1 each  registered result; held until the next DONE.
- CYCLES  out  clog2(NIBBLES+1)  number of nibbles examined for the last result.

## Operation
- States: IDLE, RUN.
- IDLE: START=1 at an edge latches A, B and I={IAgB,IAeB,IAlB}, sets idx=NIBBLES-1 and cnt=0, and moves to RUN with BUSY=1.
- RUN, each edge: compare A[4idx+3:4idx] with B[4idx+3:4idx] and increment cnt.
  - A nibble > B nibble: result=100.
  - A nibble < B nibble: result=001.
  - Nibbles equal and idx>0: decrement idx and stay in RUN.
  - Nibbles equal and idx==0: result is taken from I:
    - I=100 gives 100.
    - I=010 gives 010.
    - I=001 gives 001.
    - I=000 gives 110.
    - Any other I gives 000.
  - On any result: Q is registered, CYCLES is set to the new cnt, DONE=1, BUSY=0, and the state returns to IDLE.
- START while BUSY is ignored; the operand latch is not disturbed.
- START asserted in the same cycle DONE is high is accepted, because the state is already IDLE.
- Operand inputs may change freely after the accepting edge.
- NIBBLES=1 degenerates to a single-cycle compare.

## Timing
- Reset values: state=IDLE, BUSY=0, DONE=0, Q=000, CYCLES=0, latches cleared.
- Accepting edge k: BUSY is high from edge k.
- If the decision occurs at nibble m (1 ≤ m ≤ NIBBLES), counted from the MSB:
  - Q, CYCLES and DONE update at edge k+m.
  - DONE is high for exactly the cycle between edges k+m and k+m+1.
- Latency ranges from 1 cycle (MSB differs) to NIBBLES cycles (all nibbles equal).
- Back-to-back requests have a throughput of one request per m+1... minimum: a new START can be accepted at edge k+m+1.
- RST asserted mid-RUN: immediately IDLE and all outputs at reset values. No DONE is produced for the aborted request.
- Q is never combinationally dependent on inputs; all outputs are registers.

## Structure
- Package sysu_cmp_pkg:
  - State encoding: IDLE=1'b0, RUN=1'b1.
  - Result constants: CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001, CMP_AMB=3'b110, CMP_NONE=3'b000.
- One sub-module is natural: sysu_nibble_cmp.
  - Purely combinational 4-bit compare with cascade resolution, as specified above.
  - Instantiated once and fed by the idx-selected nibble mux.
  - Its cascade inputs are driven with CMP_EQ on non-final nibbles and with I on idx==0.

## Test plan
- NIBBLES=4, A=16'h8000, B=16'h7FFF, I=010, START pulse: DONE one cycle after the accepting edge, Q=100, CYCLES=1.
- A=16'h12A4, B=16'h12B4: DONE 3 cycles after acceptance, Q=001, CYCLES=3.
- A=B=16'h1234, with I set in turn to 010, 100, 000 and 111: DONE after 4 cycles with Q=010, 100, 110 and 000 respectively; CYCLES=4 in each case.
- START pulsed during BUSY with different operands: ignored, and the first request's result is unchanged. A START held high in the DONE cycle launches a second compare, with BUSY high from the next edge.
- RST asserted asynchronously two cycles into a 4-nibble equal compare: BUSY=0, Q=000 and CYCLES=0 immediately. No DONE pulse appears, and a fresh START afterwards completes normally.
- NIBBLES=1 build, A=4'h3, B=4'h5: DONE one cycle after acceptance, Q=001.

Source files
------------

// File: rtl/sysu_cmp_pkg.sv
// Shared encodings for the serial wide-word comparator controller.
package sysu_cmp_pkg;

  // Controller state encoding
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // Result encodings {gt, eq, lt}
  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_AMB  = 3'b110;
  localparam logic [2:0] CMP_NONE = 3'b000;

  // Width of a nibble index; kept at least one bit so a single-nibble build is legal
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sysu_nibble_cmp.sv
// Combinational 4-bit magnitude compare with cascade-input resolution.
module sysu_nibble_cmp
  import sysu_cmp_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [2:0] i_casc,
  output logic [2:0] o_res
);

  // Nibble magnitude decides first; equal nibbles defer to the cascade inputs
  always_comb begin
    o_res = CMP_NONE;
    if (i_a > i_b) begin
      o_res = CMP_GT;
    end else if (i_a < i_b) begin
      o_res = CMP_LT;
    end else begin
      case (i_casc)
        CMP_GT:   o_res = CMP_GT;
        CMP_EQ:   o_res = CMP_EQ;
        CMP_LT:   o_res = CMP_LT;
        3'b000:   o_res = CMP_AMB;
        default:  o_res = CMP_NONE;
      endcase
    end
  end

endmodule

// File: rtl/sysu_serial_cmp_ctrl.sv
// Serial MSB-first wide-word comparator built around one 4-bit slice.
module sysu_serial_cmp_ctrl
  import sysu_cmp_pkg::*;
#(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W      = 4 * NIBBLES,
  localparam int unsigned CW     = $clog2(NIBBLES + 1),
  localparam int unsigned IDXW   = idx_width(NIBBLES)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic          IAgB,
  input  logic          IAeB,
  input  logic          IAlB,
  output logic          BUSY,
  output logic          DONE,
  output logic          QAgB,
  output logic          QAeB,
  output logic          QAlB,
  output logic [CW-1:0] CYCLES
);

  logic            r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [2:0]      r_casc;
  logic [IDXW-1:0] r_idx;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_q;

  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic            w_last;
  logic [2:0]      w_casc;
  logic [2:0]      w_res;
  logic            w_decided;

  // Select the current nibble pair from the operand latches
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int unsigned n = 0; n < NIBBLES; n++) begin
      if (r_idx == n[IDXW-1:0]) begin
        w_a_nib = r_a[4*n +: 4];
        w_b_nib = r_b[4*n +: 4];
      end
    end
  end

  // Only the least-significant nibble sees the captured cascade inputs
  always_comb begin
    w_last    = (r_idx == '0);
    w_casc    = w_last ? r_casc : CMP_EQ;
    w_decided = (w_a_nib != w_b_nib) || w_last;
  end

  sysu_nibble_cmp u_nibble_cmp (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_casc (w_casc),
    .o_res  (w_res)
  );

  // Control FSM: capture on START, walk nibbles MSB-first, publish result once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_casc  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_q     <= CMP_NONE;
      CYCLES  <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_a     <= A;
            r_b     <= B;
            r_casc  <= {IAgB, IAeB, IAlB};
            r_idx   <= IDXW'(NIBBLES - 1);
            r_cnt   <= '0;
            BUSY    <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_decided) begin
            r_q     <= w_res;
            CYCLES  <= r_cnt + CW'(1);
            DONE    <= 1'b1;
            BUSY    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_idx <= r_idx - IDXW'(1);
          end
        end
      endcase
    end
  end

  assign {QAgB, QAeB, QAlB} = r_q;

endmodule

// File: tb/tb_sysu_serial_cmp_ctrl.sv
// Directed bench for the serial comparator: 4-nibble and 1-nibble builds.
module tb_sysu_serial_cmp_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic        start0 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0;
  logic [2:0]  i0 = 3'b010;
  logic        busy0, done0, qg0, qe0, ql0;
  logic [2:0]  cyc0;

  logic        start1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic [2:0]  i1 = 3'b010;
  logic        busy1, done1, qg1, qe1, ql1;
  logic [0:0]  cyc1;

  int n_total = 0;
  int n_bad   = 0;
  int lat;

  always #5 CLK = ~CLK;

  sysu_serial_cmp_ctrl #(.NIBBLES(4)) dut4 (
    .CLK(CLK), .RST(RST), .START(start0), .A(a0), .B(b0),
    .IAgB(i0[2]), .IAeB(i0[1]), .IAlB(i0[0]),
    .BUSY(busy0), .DONE(done0), .QAgB(qg0), .QAeB(qe0), .QAlB(ql0),
    .CYCLES(cyc0)
  );

  sysu_serial_cmp_ctrl #(.NIBBLES(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(start1), .A(a1), .B(b1),
    .IAgB(i1[2]), .IAeB(i1[1]), .IAlB(i1[0]),
    .BUSY(busy1), .DONE(done1), .QAgB(qg1), .QAeB(qe1), .QAlB(ql1),
    .CYCLES(cyc1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Drive a one-cycle START at a negedge; returns at the negedge after the accepting edge
  task automatic req4(input logic [15:0] a, input logic [15:0] b, input logic [2:0] i);
    @(negedge CLK);
    start0 = 1'b1; a0 = a; b0 = b; i0 = i;
    @(negedge CLK);
    start0 = 1'b0; a0 = ~a; b0 = ~b; i0 = ~i;
  endtask

  // Counts negedges until DONE is seen; 99 on timeout
  task automatic wait_done(input bit sel, output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if ((sel ? done1 : done0) === 1'b1) begin
        n = k;
        return;
      end
    end
    n = 99;
  endtask

  task automatic run4(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] i, input int m, input logic [2:0] q);
    req4(a, b, i);
    chk({tag, ".busy"}, 32'(busy0), 32'd1);
    wait_done(1'b0, lat);
    chk({tag, ".lat"}, 32'(lat), 32'(m));
    chk({tag, ".q"}, 32'({qg0, qe0, ql0}), 32'(q));
    chk({tag, ".cyc"}, 32'(cyc0), 32'(m));
    chk({tag, ".busy_end"}, 32'(busy0), 32'd0);
    @(negedge CLK);
    chk({tag, ".done_pulse"}, 32'(done0), 32'd0);
  endtask

  initial begin
    #2;
    chk("rst.busy", 32'(busy0), 32'd0);
    chk("rst.done", 32'(done0), 32'd0);
    chk("rst.q", 32'({qg0, qe0, ql0}), 32'd0);
    chk("rst.cyc", 32'(cyc0), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    run4("msb_gt", 16'h8000, 16'h7FFF, 3'b010, 1, 3'b100);
    run4("nib3_lt", 16'h12A4, 16'h12B4, 3'b010, 3, 3'b001);
    run4("eq_i010", 16'h1234, 16'h1234, 3'b010, 4, 3'b010);
    run4("eq_i100", 16'h1234, 16'h1234, 3'b100, 4, 3'b100);
    run4("eq_i000", 16'h1234, 16'h1234, 3'b000, 4, 3'b110);
    run4("eq_i111", 16'h1234, 16'h1234, 3'b111, 4, 3'b000);

    // START during BUSY must not disturb the running request
    req4(16'h5555, 16'h5556, 3'b010);
    @(negedge CLK);
    start0 = 1'b1; a0 = 16'hFFFF; b0 = 16'h0000; i0 = 3'b100;
    @(negedge CLK);
    start0 = 1'b0;
    wait_done(1'b0, lat);
    chk("ign.lat", 32'(lat), 32'd2);
    chk("ign.q", 32'({qg0, qe0, ql0}), 32'(3'b001));
    chk("ign.cyc", 32'(cyc0), 32'd4);
    // START held in the DONE cycle is accepted at the next edge
    start0 = 1'b1; a0 = 16'h0F00; b0 = 16'h0E00; i0 = 3'b010;
    @(negedge CLK);
    start0 = 1'b0; a0 = '0; b0 = '1;
    chk("b2b.busy", 32'(busy0), 32'd1);
    chk("b2b.done_low", 32'(done0), 32'd0);
    wait_done(1'b0, lat);
    chk("b2b.lat", 32'(lat), 32'd2);
    chk("b2b.q", 32'({qg0, qe0, ql0}), 32'(3'b100));
    chk("b2b.cyc", 32'(cyc0), 32'd2);

    // Asynchronous reset mid-run
    req4(16'h1234, 16'h1234, 3'b010);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst.busy", 32'(busy0), 32'd0);
    chk("arst.q", 32'({qg0, qe0, ql0}), 32'd0);
    chk("arst.cyc", 32'(cyc0), 32'd0);
    chk("arst.done", 32'(done0), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    wait_done(1'b0, lat);
    chk("arst.no_done", 32'(lat), 32'd99);
    run4("arst.fresh", 16'h8000, 16'h7FFF, 3'b010, 1, 3'b100);

    // Single-nibble build
    @(negedge CLK);
    start1 = 1'b1; a1 = 4'h3; b1 = 4'h5; i1 = 3'b010;
    @(negedge CLK);
    start1 = 1'b0; a1 = 4'hF; b1 = 4'h0;
    chk("n1.busy", 32'(busy1), 32'd1);
    wait_done(1'b1, lat);
    chk("n1.lat", 32'(lat), 32'd1);
    chk("n1.q", 32'({qg1, qe1, ql1}), 32'(3'b001));
    chk("n1.cyc", 32'(cyc1), 32'd1);
    chk("n1.busy_end", 32'(busy1), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
